// File: rtl/aes_pkg.sv
// Shared types and constant tables for the AES-128 key scheduler:
// word/key typedefs, FSM state enum, rcon table and S-box.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return (r < 4'd10) ? RCON[r] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Start/round-key streaming bundle for the key scheduler; the key-store read
// port exists only when AES_KEY_STORE_EN is defined.
interface aes_key_scheduler_if;
    import aes_pkg::*;

    logic       start;
    key_t       key_in;
    logic       ready;
    logic       rk_valid;
    logic       rk_ready;
    key_t       rk_out;
    logic [3:0] rk_round;
    logic       rk_last;
`ifdef AES_KEY_STORE_EN
    logic [3:0] ks_addr;
    key_t       ks_key;

    modport master (
        output start, key_in, rk_ready, ks_addr,
        input  ready, rk_valid, rk_out, rk_round, rk_last, ks_key
    );
    modport slave (
        input  start, key_in, rk_ready, ks_addr,
        output ready, rk_valid, rk_out, rk_round, rk_last, ks_key
    );
`else
    modport master (
        output start, key_in, rk_ready,
        input  ready, rk_valid, rk_out, rk_round, rk_last
    );
    modport slave (
        input  start, key_in, rk_ready,
        output ready, rk_valid, rk_out, rk_round, rk_last
    );
`endif

endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 key scheduler streaming one round key per cycle under valid/ready.
// Define AES_KEY_STORE_EN to keep every round key in a readable register store.
//
// state | meaning
// IDLE  | ready for start; rk_out/rk_round hold the last values
// RUN   | rk_valid high, presenting round rk_round
module aes_key_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clk,
    input  logic                reset,
    aes_key_scheduler_if.slave  bus
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    key_t       rk_out_q, rk_out_d;
    logic [3:0] rk_round_q, rk_round_d;
    logic       load;

    word_t w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_out_q;
    assign rot = {w3[23:0], w3[31:24]};

    aes_subword u_subword (
        .word_i (rot),
        .word_o (sub)
    );

    assign n0 = w0 ^ sub ^ {rcon(rk_round_q), 24'h000000};
    assign n1 = n0 ^ w1;
    assign n2 = n1 ^ w2;
    assign n3 = n2 ^ w3;

    always_comb begin
        state_d    = state_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    rk_out_d   = bus.key_in;
                    rk_round_d = 4'd0;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (bus.rk_ready) begin
                    if (rk_round_q == LAST_RND) begin
                        state_d = IDLE;
                    end else begin
                        rk_out_d   = {n0, n1, n2, n3};
                        rk_round_d = rk_round_q + 4'd1;
                        load       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rk_out_q   <= '0;
            rk_round_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.rk_valid = (state_q == RUN);
    assign bus.rk_out   = rk_out_q;
    assign bus.rk_round = rk_round_q;
    assign bus.rk_last  = (state_q == RUN) && (rk_round_q == LAST_RND);

`ifdef AES_KEY_STORE_EN
    key_t store_q [NUM_ROUNDS+1];

    // Written as each key is loaded, i.e. the cycle before it is first valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else if (load) begin
            store_q[rk_round_d] <= rk_out_d;
        end
    end

    assign bus.ks_key = (bus.ks_addr <= LAST_RND) ? store_q[bus.ks_addr] : '0;
`else
    logic unused_load;
    assign unused_load = load;
`endif

endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 Parameter NUM_ROUNDS, default 10: number of expansion rounds; legal range 1..10, limited by the 10-entry rcon table.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to expand key_in; accepted only when ready=1.
REQ-005 key_in  input  128  cipher key; w0=key_in[127:96] .. w3=key_in[31:0]; sampled on accept.
REQ-006 ready  output  1  high in IDLE; start is accepted in a cycle with start&&ready.
REQ-007 rk_valid  output  1  round key on rk_out is valid.
REQ-008 rk_ready  input  1  consumer accepts the round key; transfer occurs when rk_valid&&rk_ready.
REQ-009 rk_out  output  128  current round key, same word order as key_in.
REQ-010 rk_round  output  4  index of rk_out, 0..NUM_ROUNDS.
REQ-011 rk_last  output  1  high with rk_valid when rk_round==NUM_ROUNDS.
REQ-012 ks_addr  input  4  key-store read index; present only with AES_KEY_STORE_EN.
REQ-013 ks_key  output  128  key-store read data; present only with AES_KEY_STORE_EN.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN; ready=1 only in IDLE.
REQ-015 When start&&ready: next cycle state=RUN, rk_valid=1, rk_round=0, rk_out=key_in.
REQ-016 On each transfer with rk_round<NUM_ROUNDS, the next cycle SHALL present round r+1 from round r (words w0..w3): n0=w0^SubWord(RotWord(w3))^{rcon[r],24'h0}; n1=n0^w1; n2=n1^w2; n3=n2^w3.
REQ-017 RotWord SHALL rotate left by one byte; SubWord SHALL apply the AES S-box to each byte; rcon[0..9] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-018 Throughput SHALL be one round key per cycle when rk_ready is held high: NUM_ROUNDS+1 consecutive valid cycles.
REQ-019 With rk_valid&&!rk_ready, rk_out, rk_round and rk_last SHALL hold stable and no expansion SHALL occur.
REQ-020 On the transfer of the round NUM_ROUNDS key, the next cycle SHALL be IDLE with rk_valid=0 and ready=1; no idle gap beyond that single cycle.
REQ-021 start while in RUN SHALL be ignored; key_in changes in RUN SHALL have no effect.
REQ-022 rk_out and rk_round SHALL hold their last values while in IDLE; only rk_valid qualifies them.

Reset
REQ-023 reset SHALL force IDLE and ready=1, and clear rk_valid, rk_last, rk_round and rk_out to 0 on the next edge.
REQ-024 reset SHALL take priority over start and over an in-progress RUN; the partial expansion is discarded.
REQ-025 With AES_KEY_STORE_EN, reset SHALL clear all key-store entries to 0.

Configuration
REQ-026 Macro AES_KEY_STORE_EN defined: each round key is written into an (NUM_ROUNDS+1)x128 register store at index rk_round when it first becomes valid.
REQ-027 ks_key SHALL be a combinational read of store[ks_addr]; an out-of-range ks_addr SHALL return 0.
REQ-028 Store contents SHALL persist until reset or until a new start overwrites them (decryption reuse).
REQ-029 Macro undefined: ks_addr and ks_key SHALL be absent and no store SHALL be built; streaming behaviour is identical in both builds.

Structure
REQ-030 Package aes_pkg SHALL hold the rcon table, the S-box table, the state enum (IDLE, RUN) and typedefs word_t (32b) and key_t (128b).
REQ-031 One sub-module, aes_subword (4 parallel S-box lookups, 32b in/out), SHALL be instantiated once; the rcon XOR is inline.

Verification
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, 11 contiguous valid cycles.
REQ-033 Same key, rk_ready=0 for 3 cycles at round 4 -> rk_out stays at round-4 value, rk_round stays 4; resumes with the correct round 5.
REQ-034 start pulsed at round 6 with a different key_in -> ignored; round 7..10 values unchanged.
REQ-035 reset asserted at round 5 -> next cycle rk_valid=0, rk_out=0, ready=1; a new start then yields a correct round 0.
REQ-036 AES_KEY_STORE_EN, after full expansion, ks_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; ks_addr=15 -> 0.
REQ-037 Back-to-back: start issued in the cycle after the round-10 transfer -> accepted, new round 0 presented on the following cycle.
